// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and character helper for the LCD hex display.
package lcd_pkg;

   // HD44780 command bytes
   localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CLEAR    = 8'h01;  // clear display (slow command)
   localparam logic [7:0] ENTRY    = 8'h06;  // increment address, no shift
   localparam logic [7:0] LINE0    = 8'h80;  // DDRAM address 0x00
   localparam logic [7:0] LINE1    = 8'hC0;  // DDRAM address 0x40

   typedef enum logic [1:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_REFRESH
   } state_e;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_SETUP,
      WR_EN,
      WR_WAIT
   } wr_phase_e;

   // 0-9 -> '0'-'9', A-F -> 'A'-'F'
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      logic [7:0] ch;
      if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
      else             ch = 8'h37 + {4'h0, nib};
      return ch;
   endfunction

   // Init command sequence, in the order it is sent
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = FUNC_SET;
         2'd1:    cmd = DISP_ON;
         2'd2:    cmd = CLEAR;
         default: cmd = ENTRY;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one LCD bus transaction: a setup cycle, an EN pulse, then a hold/wait.
// A new byte may be started in the cycle oDone is high so bytes chain with no gap.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int EN_PULSE_CYC   = 16,
   parameter int CMD_WAIT_CYC   = 2000,
   parameter int CLEAR_WAIT_CYC = 82000,
   parameter int CNT_W          = 17
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iStart,
   input  logic       iRS,
   input  logic [7:0] iByte,
   input  logic       iLong,
   output logic       oDone,
   output logic       LCD_EN,
   output logic       LCD_RS,
   output logic [7:0] LCD_DATA
);

   wr_phase_e        phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q, en_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             long_q, long_d;
   logic             done;

   assign done     = (phase_q == WR_WAIT) && (cnt_q == '0);
   assign oDone    = done;
   assign LCD_EN   = en_q;
   assign LCD_RS   = rs_q;
   assign LCD_DATA = data_q;

   // Phase sequencing; RS/DATA only load on a start, so they are frozen while EN is high
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      rs_d    = rs_q;
      data_d  = data_q;
      long_d  = long_q;
      case (phase_q)
         WR_SETUP: begin
            phase_d = WR_EN;
            en_d    = 1'b1;
            cnt_d   = CNT_W'(EN_PULSE_CYC - 1);
         end
         WR_EN: begin
            if (cnt_q == '0) begin
               phase_d = WR_WAIT;
               en_d    = 1'b0;
               cnt_d   = long_q ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_WAIT: begin
            if (cnt_q == '0) phase_d = WR_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: ;
      endcase
      if (iStart && (phase_q == WR_IDLE || done)) begin
         phase_d = WR_SETUP;
         en_d    = 1'b0;
         rs_d    = iRS;
         data_d  = iByte;
         long_d  = iLong;
      end
   end

   // State registers; reset drops EN immediately, even mid-pulse
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         phase_q <= WR_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         long_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         long_q  <= long_d;
      end
   end

endmodule

// File: rtl/lcd_multi_hex_display.sv
// Latches up to NUM_WORDS words and shows each in hex on its own 16x2 LCD line.
// Owns power-up wait, HD44780 init and refresh-on-change sequencing.
module lcd_multi_hex_display
   import lcd_pkg::*;
#(
   parameter int WORD_W         = 32,
   parameter int NUM_WORDS      = 2,
   parameter int SEL_W          = 1,
   parameter int EN_PULSE_CYC   = 16,
   parameter int CMD_WAIT_CYC   = 2000,
   parameter int CLEAR_WAIT_CYC = 82000,
   parameter int POWERUP_CYC    = 750000
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iSET,
   input  logic [SEL_W-1:0]  iSEL,
   input  logic [WORD_W-1:0] iDATA,
   output logic              oREADY,
   output logic              oBUSY,
   output logic [7:0]        LCD_DATA,
   output logic              LCD_RW,
   output logic              LCD_EN,
   output logic              LCD_RS
);

   localparam int NCH      = WORD_W / 4;
   localparam int MAX_A    = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_B    = (CMD_WAIT_CYC > EN_PULSE_CYC) ? CMD_WAIT_CYC : EN_PULSE_CYC;
   localparam int WAIT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   state_e                             state_q, state_d;
   logic [WAIT_W-1:0]                  wait_q, wait_d;
   logic [1:0]                         idx_q, idx_d;
   logic                               line_q, line_d;
   logic [3:0]                         char_q, char_d;
   logic                               in_cmd_q, in_cmd_d;
   logic                               dirty_q, dirty_d;
   logic                               ready_q, ready_d;
   logic                               busy_q, busy_d;
   logic [NUM_WORDS-1:0][WORD_W-1:0]   shadow_q, shadow_d;
   logic [NUM_WORDS-1:0][WORD_W-1:0]   disp_q, disp_d;

   logic              start, st_rs, st_long, wr_done;
   logic [7:0]        st_byte;
   logic [WORD_W-1:0] cur_word;
   logic [3:0]        nxt_char;
   logic [5:0]        sh;
   logic [7:0]        nxt_ascii;

   assign oREADY = ready_q;
   assign oBUSY  = busy_q;
   assign LCD_RW = 1'b0;

   // Next character to send: the first one right after the line command, else the following one
   always_comb begin
      cur_word = '0;
      for (int w = 0; w < NUM_WORDS; w++)
         if (32'(line_q) == w) cur_word = disp_q[w];
      nxt_char  = in_cmd_q ? 4'd0 : char_q + 4'd1;
      sh        = 6'(4 * (NCH - 1)) - {nxt_char, 2'b00};
      nxt_ascii = hex_to_ascii(4'(cur_word >> sh));
   end

   // Sequencer, capture and snapshot logic
   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      idx_d    = idx_q;
      line_d   = line_q;
      char_d   = char_q;
      in_cmd_d = in_cmd_q;
      dirty_d  = dirty_q;
      ready_d  = ready_q;
      shadow_d = shadow_q;
      disp_d   = disp_q;
      start    = 1'b0;
      st_rs    = 1'b0;
      st_byte  = 8'h00;
      case (state_q)
         ST_PWRUP: begin
            if (wait_q == WAIT_W'(POWERUP_CYC - 1)) begin
               state_d = ST_INIT;
               idx_d   = 2'd0;
               start   = 1'b1;
               st_byte = init_cmd(2'd0);
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_INIT: begin
            if (wr_done) begin
               if (idx_q == 2'd3) begin
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  start   = 1'b1;
                  st_byte = init_cmd(idx_q + 2'd1);
               end
            end
         end
         ST_IDLE: begin
            // Snapshot uses the shadows as of the previous edge; the line-0
            // command does not depend on them, so it starts in the same cycle.
            if (dirty_q) begin
               disp_d   = shadow_q;
               dirty_d  = 1'b0;
               state_d  = ST_REFRESH;
               line_d   = 1'b0;
               in_cmd_d = 1'b1;
               start    = 1'b1;
               st_byte  = LINE0;
            end
         end
         default: begin
            if (wr_done) begin
               if (in_cmd_q) begin
                  in_cmd_d = 1'b0;
                  char_d   = 4'd0;
                  start    = 1'b1;
                  st_rs    = 1'b1;
                  st_byte  = nxt_ascii;
               end else if (char_q == 4'(NCH - 1)) begin
                  if (32'(line_q) == NUM_WORDS - 1) begin
                     state_d = ST_IDLE;
                  end else begin
                     line_d   = 1'b1;
                     in_cmd_d = 1'b1;
                     start    = 1'b1;
                     st_byte  = LINE1;
                  end
               end else begin
                  char_d  = nxt_char;
                  start   = 1'b1;
                  st_rs   = 1'b1;
                  st_byte = nxt_ascii;
               end
            end
         end
      endcase
      // A capture always wins over the snapshot's dirty clear
      for (int w = 0; w < NUM_WORDS; w++)
         if (iSET && (32'(iSEL) == w)) begin
            shadow_d[w] = iDATA;
            dirty_d     = 1'b1;
         end
      st_long = !st_rs && (st_byte == CLEAR);
      busy_d  = (state_d != ST_IDLE) || dirty_d;
   end

   // State registers
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q  <= ST_PWRUP;
         wait_q   <= '0;
         idx_q    <= 2'd0;
         line_q   <= 1'b0;
         char_q   <= 4'd0;
         in_cmd_q <= 1'b0;
         dirty_q  <= 1'b1;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
         shadow_q <= '0;
         disp_q   <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         idx_q    <= idx_d;
         line_q   <= line_d;
         char_q   <= char_d;
         in_cmd_q <= in_cmd_d;
         dirty_q  <= dirty_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
      end
   end

   lcd_byte_writer #(
      .EN_PULSE_CYC  (EN_PULSE_CYC),
      .CMD_WAIT_CYC  (CMD_WAIT_CYC),
      .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC),
      .CNT_W         (WAIT_W)
   ) u_writer (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .iStart  (start),
      .iRS     (st_rs),
      .iByte   (st_byte),
      .iLong   (st_long),
      .oDone   (wr_done),
      .LCD_EN  (LCD_EN),
      .LCD_RS  (LCD_RS),
      .LCD_DATA(LCD_DATA)
   );

endmodule

// File: tb/tb_lcd_multi_hex_display.sv
// Directed bench for lcd_multi_hex_display: init sequence, refresh contents,
// snapshot behaviour, ignored selects, async reset and bus protocol.
module tb_lcd_multi_hex_display;

   localparam int PWR  = 100;
   localparam int ENP  = 4;
   localparam int CMDW = 10;
   localparam int CLRW = 40;

   localparam logic [7:0] INIT_B [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
   localparam logic [7:0] DB_B   [8] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
   localparam logic [7:0] AB_B   [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44};

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        set = 1'b0, sel = 1'b0;
   logic [31:0] data = '0;
   logic        ready, busy, lrw, len, lrs;
   logic [7:0]  ldata;
   logic        set1 = 1'b0, sel1 = 1'b0;
   logic [31:0] data1 = '0;
   logic        ready1, busy1, lrw1, len1, lrs1;
   logic [7:0]  ldata1;

   int checks = 0, failures = 0, cyc = 0;

   always #5 clk = ~clk;

   lcd_multi_hex_display #(.WORD_W(32), .NUM_WORDS(2), .SEL_W(1), .EN_PULSE_CYC(ENP),
      .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW), .POWERUP_CYC(PWR)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iSET(set), .iSEL(sel), .iDATA(data),
      .oREADY(ready), .oBUSY(busy), .LCD_DATA(ldata), .LCD_RW(lrw), .LCD_EN(len), .LCD_RS(lrs));

   lcd_multi_hex_display #(.WORD_W(32), .NUM_WORDS(1), .SEL_W(1), .EN_PULSE_CYC(ENP),
      .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW), .POWERUP_CYC(PWR)) dut1 (
      .iCLK(clk), .iRST_N(rst_n), .iSET(set1), .iSEL(sel1), .iDATA(data1),
      .oREADY(ready1), .oBUSY(busy1), .LCD_DATA(ldata1), .LCD_RW(lrw1), .LCD_EN(len1), .LCD_RS(lrs1));

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         rise;
      int         fall;
   } pulse_t;

   pulse_t pq[$];
   pulse_t cur;
   logic   prev_en = 1'b0, prev_ready = 1'b0, prev_en1 = 1'b0;
   int     en_len = 0, ready_cyc = -1, en1_cnt = 0;
   bit     stable = 1'b1;

   // Bus monitor, sampled 1 time unit after each rising edge
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst_n) begin
         prev_en = 1'b0; prev_ready = 1'b0; prev_en1 = 1'b0; en_len = 0;
      end else begin
         checks++;
         if (lrw !== 1'b0 || lrw1 !== 1'b0) begin
            failures++;
            $display("FAIL lcd_rw cyc=%0d got=%b/%b want=0", cyc, lrw, lrw1);
         end
         if (ready === 1'b1 && !prev_ready) ready_cyc = cyc;
         prev_ready = ready;
         if (len1 === 1'b1 && !prev_en1) en1_cnt++;
         prev_en1 = len1;
         if (len === 1'b1 && !prev_en) begin
            cur.rs = lrs; cur.d = ldata; cur.rise = cyc; cur.fall = 0;
            en_len = 1; stable = 1'b1;
         end else if (len === 1'b1) begin
            en_len++;
            if (lrs !== cur.rs || ldata !== cur.d) stable = 1'b0;
         end else if (prev_en) begin
            cur.fall = cyc;
            pq.push_back(cur);
            checks++;
            if (en_len != ENP) begin
               failures++;
               $display("FAIL en_high_len byte=%h got=%0d want=%0d", cur.d, en_len, ENP);
            end
            checks++;
            if (!stable) begin
               failures++;
               $display("FAIL en_data_stable byte=%h changed while EN high", cur.d);
            end
         end
         prev_en = len;
      end
   end

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({len, lrs, ldata, lrw} !== 11'h0) begin
         failures++;
         $display("FAIL reset_bus got en=%b rs=%b data=%h rw=%b want all 0", len, lrs, ldata, lrw);
      end
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_flags got ready=%b busy=%b want ready=0 busy=1", ready, busy);
      end
   endtask

   task automatic test_init_refresh();
      int rel;
      @(negedge clk);
      pq.delete(); ready_cyc = -1;
      rst_n = 1'b1; rel = cyc;
      for (int i = 0; i < 2000 && !(pq.size() >= 22 && busy === 1'b0); i++) @(negedge clk);
      checks++;
      if (pq.size() != 22 || busy !== 1'b0) begin
         failures++;
         $display("FAIL init_count got pulses=%0d busy=%b want 22 and 0", pq.size(), busy);
      end
      if (pq.size() >= 22) begin
         checks++;
         if (pq[0].rise - rel <= PWR) begin
            failures++;
            $display("FAIL powerup_wait got first EN at %0d want > %0d", pq[0].rise - rel, PWR);
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (pq[i].d !== INIT_B[i] || pq[i].rs !== 1'b0) begin
               failures++;
               $display("FAIL init_byte%0d got %h rs=%b want %h rs=0", i, pq[i].d, pq[i].rs, INIT_B[i]);
            end
         end
         // spacing from EN fall to next EN rise = wait cycles + one setup cycle
         checks++;
         if (pq[1].rise - pq[0].fall != CMDW + 1) begin
            failures++;
            $display("FAIL cmd_gap got %0d want %0d", pq[1].rise - pq[0].fall, CMDW + 1);
         end
         checks++;
         if (pq[3].rise - pq[2].fall != CLRW + 1) begin
            failures++;
            $display("FAIL clear_gap got %0d want %0d", pq[3].rise - pq[2].fall, CLRW + 1);
         end
         checks++;
         if (ready_cyc != pq[3].fall + CMDW) begin
            failures++;
            $display("FAIL ready_rise got %0d want %0d", ready_cyc, pq[3].fall + CMDW);
         end
         for (int i = 0; i < 18; i++) begin
            logic [7:0] eb;
            logic       er;
            er = (i % 9) != 0;
            eb = (i == 0) ? 8'h80 : (i == 9) ? 8'hC0 : 8'h30;
            checks++;
            if (pq[4+i].d !== eb || pq[4+i].rs !== er) begin
               failures++;
               $display("FAIL first_refresh%0d got %h rs=%b want %h rs=%b", i, pq[4+i].d, pq[4+i].rs, eb, er);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      int k;
      @(negedge clk);
      pq.delete();
      set = 1'b1; sel = 1'b0; data = 32'hDEADBEEF; k = cyc + 1;
      @(negedge clk);
      set = 1'b0;
      for (int i = 0; i < 500 && pq.size() < 3; i++) @(negedge clk);
      set = 1'b1; sel = 1'b1; data = 32'h0123ABCD;
      @(negedge clk);
      set = 1'b0;
      for (int i = 0; i < 3000 && !(pq.size() >= 36 && busy === 1'b0); i++) @(negedge clk);
      checks++;
      if (pq.size() != 36 || busy !== 1'b0) begin
         failures++;
         $display("FAIL snap_count got pulses=%0d busy=%b want 36 and 0", pq.size(), busy);
      end
      if (pq.size() >= 36) begin
         checks++;
         if (pq[0].rise != k + 2) begin
            failures++;
            $display("FAIL set_latency got EN at %0d want %0d", pq[0].rise, k + 2);
         end
         for (int i = 0; i < 36; i++) begin
            int         s, j;
            logic [7:0] eb;
            logic       er;
            s = i / 9; j = i % 9;
            er = (j != 0);
            if (j == 0)      eb = (s % 2 == 1) ? 8'hC0 : 8'h80;
            else if (s == 1) eb = 8'h30;
            else if (s == 3) eb = AB_B[j-1];
            else             eb = DB_B[j-1];
            checks++;
            if (pq[i].d !== eb || pq[i].rs !== er) begin
               failures++;
               $display("FAIL snap_byte%0d got %h rs=%b want %h rs=%b", i, pq[i].d, pq[i].rs, eb, er);
            end
         end
      end
      repeat (40) @(negedge clk);
      checks++;
      if (pq.size() != 36 || busy !== 1'b0) begin
         failures++;
         $display("FAIL settle_idle got pulses=%0d busy=%b want 36 and 0", pq.size(), busy);
      end
   endtask

   task automatic test_ignored_sel();
      int  c0;
      bit  saw_busy = 1'b0;
      @(negedge clk);
      c0 = en1_cnt;
      set1 = 1'b1; sel1 = 1'b1; data1 = 32'hFFFF_FFFF;
      @(negedge clk);
      set1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy1 !== 1'b0) saw_busy = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_busy || en1_cnt != c0) begin
         failures++;
         $display("FAIL ignored_sel got busy_seen=%0d pulses=%0d want 0 and 0", saw_busy, en1_cnt - c0);
      end
      set1 = 1'b1; sel1 = 1'b0; data1 = 32'h0000_0005;
      @(negedge clk);
      set1 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 1000 && busy1 !== 1'b0; i++) @(negedge clk);
      checks++;
      if (en1_cnt - c0 != 9) begin
         failures++;
         $display("FAIL valid_sel_one_line got pulses=%0d want 9", en1_cnt - c0);
      end
   endtask

   task automatic test_reset_mid_en();
      int rel;
      @(negedge clk);
      set = 1'b1; sel = 1'b0; data = 32'h0000_0001;
      @(negedge clk);
      set = 1'b0;
      for (int i = 0; i < 200 && len !== 1'b1; i++) @(negedge clk);
      checks++;
      if (len !== 1'b1) begin
         failures++;
         $display("FAIL mid_en_reach got en=%b want 1", len);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (len !== 1'b0 || ready !== 1'b0 || busy !== 1'b1 || ldata !== 8'h00 || lrs !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got en=%b ready=%b busy=%b data=%h rs=%b want 0 0 1 00 0",
                  len, ready, busy, ldata, lrs);
      end
      @(negedge clk);
      pq.delete(); ready_cyc = -1;
      rst_n = 1'b1; rel = cyc;
      for (int i = 0; i < 2000 && !(pq.size() >= 22 && busy === 1'b0); i++) @(negedge clk);
      checks++;
      if (pq.size() != 22) begin
         failures++;
         $display("FAIL reinit_count got pulses=%0d want 22", pq.size());
      end
      if (pq.size() >= 22) begin
         checks++;
         if (pq[0].rise - rel <= PWR) begin
            failures++;
            $display("FAIL reinit_powerup got first EN at %0d want > %0d", pq[0].rise - rel, PWR);
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (pq[i].d !== INIT_B[i] || pq[i].rs !== 1'b0) begin
               failures++;
               $display("FAIL reinit_byte%0d got %h want %h", i, pq[i].d, INIT_B[i]);
            end
         end
         checks++;
         if (ready_cyc != pq[3].fall + CMDW) begin
            failures++;
            $display("FAIL reinit_ready got %0d want %0d", ready_cyc, pq[3].fall + CMDW);
         end
         // shadow was 0x00000001 before reset; it must be cleared back to zero
         checks++;
         if (pq[12].d !== 8'h30) begin
            failures++;
            $display("FAIL shadow_cleared got %h want 30", pq[12].d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init_refresh();
      test_snapshot();
      test_ignored_sel();
      test_reset_mid_en();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_multi_hex_display.md
Name: lcd_multi_hex_display

Overview:
Parametrised successor to the single-word LCD message block. It latches up to NUM_WORDS processor words, each via an explicit select and strobe. It owns the full HD44780 power-up and init sequence, the byte timing, and refresh-on-change. Each word is rendered in hex on its own line of a 16x2 character LCD. It sits between the MIPS datapath (register write port / output instruction) and the board LCD pins.

Parameters:
WORD_W, 32, bits per displayed word; multiple of 4, 4..64 (at most 16 hex chars per line)
NUM_WORDS, 2, number of words/lines shown; 1 or 2
SEL_W, 1, width of iSEL; max(1, clog2(NUM_WORDS))
EN_PULSE_CYC, 16, iCLK cycles LCD_EN is held high per byte
CMD_WAIT_CYC, 2000, cycles after EN falls before the next byte (normal command or data)
CLEAR_WAIT_CYC, 82000, post-byte wait after the clear command 0x01
POWERUP_CYC, 750000, cycles waited after reset before the first init command

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iSET  in  1  capture strobe, single-cycle
iSEL  in  SEL_W  word index to write
iDATA  in  WORD_W  value to capture
oREADY  out  1  high once the init sequence has completed
oBUSY  out  1  high when not idle or a refresh is pending
LCD_DATA  out  8  LCD data bus
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  LCD enable strobe
LCD_RS  out  1  0 = command, 1 = character data

Behaviour:
- Reset (async, iRST_N=0), applied immediately, including mid-byte:
  - shadow words = 0, dirty = 1
  - LCD_EN = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00
  - oREADY = 0, oBUSY = 1
  - FSM enters PWRUP.
- Capture:
  - iSET=1 with iSEL<NUM_WORDS: shadow[iSEL] <= iDATA at that edge and dirty <= 1. This is accepted in every state, including mid-refresh.
  - iSEL>=NUM_WORDS: ignored, dirty unchanged.
- FSM states: PWRUP -> INIT -> IDLE -> REFRESH -> IDLE.
  - PWRUP: count POWERUP_CYC cycles, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x01, 0x06 in order. After the last byte's wait, oREADY <= 1 (stays 1 until reset) and go to IDLE.
  - IDLE: if dirty, copy all shadows into the display buffer, clear dirty in the same cycle, and go to REFRESH.
  - REFRESH: for line L = 0..NUM_WORDS-1:
    - send command 0x80 | (L ? 0x40 : 0x00)
    - then send WORD_W/4 data bytes, MSB nibble first, with nibble 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46.
    - After the last byte's wait, return to IDLE.
- Snapshot rule: a capture during REFRESH does not alter the bytes being sent. It re-sets dirty, so exactly one further refresh follows. A capture in the same cycle as the IDLE snapshot wins: the new value is snapshotted only if its edge precedes the snapshot edge; otherwise dirty stays set.
- Byte transaction:
  - cycle 0: LCD_RS and LCD_DATA set, LCD_EN=0 (setup)
  - cycles 1..EN_PULSE_CYC: LCD_EN=1
  - then LCD_EN=0 with LCD_RS/LCD_DATA held for CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC cycles when the byte is command 0x01.
  - LCD_RS/LCD_DATA never change while LCD_EN=1.
- Latency: in IDLE with oREADY=1, iSET at edge k gives the snapshot at edge k+1 and the setup cycle at k+1. LCD_EN rises at edge k+2.
- oBUSY = (state != IDLE) | dirty, registered.
- Counters: one wait counter, wide enough for max(POWERUP_CYC, CLEAR_WAIT_CYC). Character index counter from 0 to WORD_W/4-1; line counter wraps to IDLE after NUM_WORDS-1.
- The first refresh occurs automatically after INIT (dirty=1 from reset), showing all zeros.

Decomposition:
- Package lcd_pkg:
  - command constants: FUNC_SET=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY=0x06, LINE0=0x80, LINE1=0xC0
  - FSM state enum
  - hex_to_ascii function (4-bit in, 8-bit ASCII out).
- Sub-module lcd_byte_writer: inputs iStart, iRS, iByte, iLong; outputs oDone, LCD_EN, LCD_RS, LCD_DATA. It owns the setup/EN/wait timing. The top holds the shadows, dirty flag, sequencing FSM and counters.

Test Plan:
(Sim parameters: POWERUP_CYC=100, EN_PULSE_CYC=4, CMD_WAIT_CYC=10, CLEAR_WAIT_CYC=40.)
- Reset release, no stimulus -> no EN pulse for 100 cycles. Then EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0, and the gap after 0x01 is 40 cycles. oREADY rises after the 0x06 wait. Then 0x80 + eight 0x30, 0xC0 + eight 0x30 follow, and oBUSY falls.
- After idle: iSET, iSEL=0, iDATA=0xDEADBEEF -> EN rises 2 cycles later. Bytes are 0x80, 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46 (RS=1), then line 1 shows the unchanged zeros.
- iSET iSEL=1 iDATA=0x0123ABCD mid-refresh -> the current refresh completes with old values. One more refresh follows with line 1 = 0x30,0x31,0x32,0x33,0x41,0x42,0x43,0x44. Then IDLE.
- NUM_WORDS=1, iSET with iSEL=1 -> ignored: oBUSY stays 0 and no EN pulses.
- iRST_N low while LCD_EN=1 -> LCD_EN=0 and oREADY=0 in the same cycle (async). The full PWRUP/INIT sequence repeats after release.
- Protocol checker throughout: LCD_DATA/LCD_RS stable whenever LCD_EN=1, EN high exactly 4 cycles, LCD_RW always 0.
